// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALUOp encodings and register index width.
package pipeline_pkg;

  localparam int unsigned CTRL_W    = 8;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned FUNCT_W   = 4;

  // Bit positions inside {RegWrite, MemtoReg, Branch, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}
  localparam int unsigned CTRL_REG_WRITE  = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_BRANCH     = 5;
  localparam int unsigned CTRL_MEM_READ   = 4;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_ALU_SRC    = 2;
  localparam int unsigned CTRL_ALU_OP_HI  = 1;
  localparam int unsigned CTRL_ALU_OP_LO  = 0;

  typedef enum logic [1:0] {
    AluOpAdd    = 2'b00,
    AluOpBranch = 2'b01,
    AluOpRType  = 2'b10,
    AluOpIType  = 2'b11
  } alu_op_e;

  function automatic logic ctrlMemRead(logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a valid load in EX whose rd feeds an operand read in ID.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic                 exValid,
  input  logic                 exMemRead,
  input  logic [REG_IDX_W-1:0] exRd,
  input  logic [REG_IDX_W-1:0] idRs1,
  input  logic [REG_IDX_W-1:0] idRs2,
  input  logic                 idUsesRs1,
  input  logic                 idUsesRs2,
  output logic                 lu
);

  logic rs1Hit;
  logic rs2Hit;

  assign rs1Hit = idUsesRs1 & (idRs1 == exRd);
  assign rs2Hit = idUsesRs2 & (idRs2 == exRd);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu = exValid & exMemRead & (exRd != '0) & (rs1Hit | rs2Hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, hold and
// saturating stall/flush performance counters.
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_rdata1,
  input  logic [XLEN-1:0]      id_rdata2,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [FUNCT_W-1:0]   id_funct,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 flush,
  input  logic                 hold,
  output logic [XLEN-1:0]      ex_pc,
  output logic [XLEN-1:0]      ex_rdata1,
  output logic [XLEN-1:0]      ex_rdata2,
  output logic [XLEN-1:0]      ex_imm,
  output logic [REG_IDX_W-1:0] ex_rs1,
  output logic [REG_IDX_W-1:0] ex_rs2,
  output logic [REG_IDX_W-1:0] ex_rd,
  output logic [FUNCT_W-1:0]   ex_funct,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 ex_valid,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic lu;
  logic loadBubble;

  load_use_detect uLoadUseDetect (
    .exValid   (ex_valid),
    .exMemRead (ctrlMemRead(ex_ctrl)),
    .exRd      (ex_rd),
    .idRs1     (id_rs1),
    .idRs2     (id_rs2),
    .idUsesRs1 (id_uses_rs1),
    .idUsesRs2 (id_uses_rs2),
    .lu        (lu)
  );

  // A flush or hold overrides the hazard, so it is only reported when a bubble is really inserted
  assign hazard_stall = lu & ~flush & ~hold;
  assign pc_write     = ~(hazard_stall | hold);
  assign if_id_write  = pc_write;
  assign loadBubble   = flush | hazard_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct  <= '0;
      ex_ctrl   <= '0;
      ex_valid  <= 1'b0;
    end else if (loadBubble) begin
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct  <= '0;
      ex_ctrl   <= '0;
      ex_valid  <= 1'b0;
    end else if (!hold) begin
      ex_pc     <= id_pc;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct  <= id_funct;
      ex_ctrl   <= id_ctrl;
      ex_valid  <= 1'b1;
    end
  end

  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus randomized traffic against
// a transaction-level model of the ID/EX stage.
module tb_id_ex_stage_reg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 6;  // narrow counters so saturation is reachable quickly
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_uses_rs1, id_uses_rs2;
  logic [3:0]      id_funct;
  logic [7:0]      id_ctrl;
  logic            flush, hold;
  logic [XLEN-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [3:0]      ex_funct;
  logic [7:0]      ex_ctrl;
  logic            ex_valid, pc_write, if_id_write, hazard_stall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_pc(id_pc), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_funct(id_funct), .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
    .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_ctrl(ex_ctrl),
    .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rd1, rd2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      funct;
    logic [7:0]      ctrl;
  } stage_t;

  stage_t      m;         // model of the instruction sitting in EX
  stage_t      dutStage;
  int unsigned mStall, mFlush;
  int          checks = 0;
  int          errors = 0;

  assign dutStage = {ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm,
                     ex_rs1, ex_rs2, ex_rd, ex_funct, ex_ctrl};

  // A load in EX blocks an ID instruction that reads its (nonzero) destination
  function automatic logic modelLu();
    return m.valid && m.ctrl[4] && (m.rd != 5'd0) &&
           ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
  endfunction

  function automatic logic expStall();
    return modelLu() && !flush && !hold;
  endfunction

  function automatic logic expPcWrite();
    return !(expStall() || hold);
  endfunction

  // Advance one clock and the model with it; inputs are held stable across the edge
  task automatic tick();
    logic st;
    st = expStall();
    @(posedge clk);
    if (flush || st) m = '0;
    else if (!hold) m = {1'b1, id_pc, id_rdata1, id_rdata2, id_imm,
                         id_rs1, id_rs2, id_rd, id_funct, id_ctrl};
    if (st && mStall < CNT_MAX) mStall++;
    if (flush && mFlush < CNT_MAX) mFlush++;
    #1;
  endtask

  task automatic randData();
    id_pc = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    id_funct = 4'($urandom);
  endtask

  // Non-reading instruction that loads into rd
  task automatic setLoad(input logic [4:0] rd);
    randData();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = rd;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_ctrl = 8'hD0; flush = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset_initial();
    reset = 1'b1;
    id_pc = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_funct = '0; id_ctrl = '0; flush = 0; hold = 0;
    m = '0; mStall = 0; mFlush = 0;
    #12;
    checks++;
    if (dutStage !== stage_t'(0) || stall_cnt !== '0 || flush_cnt !== '0 ||
        pc_write !== 1'b1 || if_id_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_initial: stage=%h stall=%0d flush=%0d pcw=%b ifw=%b want 0/0/0/1/1",
               dutStage, stall_cnt, flush_cnt, pc_write, if_id_write);
    end
    reset = 1'b0;
  endtask

  task automatic test_normal();
    randData();
    id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd5; id_ctrl = 8'h81; id_imm = 32'h10;
    id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0; flush = 0; hold = 0;
    #1;
    checks++;
    if (hazard_stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL normal_comb: hazard_stall=%b pc_write=%b want 0/1", hazard_stall, pc_write);
    end
    tick();
    checks++;
    if (ex_rs1 !== 5'd3 || ex_rd !== 5'd5 || ex_ctrl !== 8'h81 || ex_imm !== 32'h10 ||
        ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL normal_capture: rs1=%0d rd=%0d ctrl=%h imm=%h valid=%b want 3/5/81/10/1",
               ex_rs1, ex_rd, ex_ctrl, ex_imm, ex_valid);
    end
    checks++;
    if (dutStage !== m) begin
      errors++;
      $display("FAIL normal_fields: got %h want %h", dutStage, m);
    end
  endtask

  task automatic test_load_use();
    setLoad(5'd7);
    tick();
    randData();
    id_rs1 = 5'd2; id_rs2 = 5'd7; id_rd = 5'd9; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    id_ctrl = 8'h82;
    #1;
    checks++;
    if (hazard_stall !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0) begin
      errors++;
      $display("FAIL load_use_comb: hazard_stall=%b pcw=%b ifw=%b want 1/0/0",
               hazard_stall, pc_write, if_id_write);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall_cnt !== CNT_W'(1) || dutStage !== m) begin
      errors++;
      $display("FAIL load_use_bubble: valid=%b ctrl=%h stall_cnt=%0d want 0/00/1",
               ex_valid, ex_ctrl, stall_cnt);
    end
    checks++;
    if (hazard_stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL load_use_release: hazard_stall=%b pcw=%b want 0/1", hazard_stall, pc_write);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs2 !== 5'd7 || ex_ctrl !== 8'h82 || stall_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL load_use_enter: valid=%b rs2=%0d ctrl=%h stall_cnt=%0d want 1/7/82/1",
               ex_valid, ex_rs2, ex_ctrl, stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    setLoad(5'd6);
    tick();
    id_rs1 = 5'd6; id_uses_rs1 = 1'b1; id_ctrl = 8'hFF;
    #1;
    reset = 1'b1;
    #1;
    m = '0; mStall = 0; mFlush = 0;
    checks++;
    if (dutStage !== stage_t'(0) || stall_cnt !== '0 || flush_cnt !== '0 ||
        pc_write !== 1'b1 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: stage=%h stall=%0d flush=%0d pcw=%b hz=%b want 0/0/0/1/0",
               dutStage, stall_cnt, flush_cnt, pc_write, hazard_stall);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || dutStage !== m || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_recover: got %h stall=%0d want %h stall=0", dutStage, stall_cnt, m);
    end
  endtask

  task automatic test_no_false_hazard();
    setLoad(5'd0);
    tick();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL no_hazard_rd0: hazard_stall=%b pcw=%b want 0/1", hazard_stall, pc_write);
    end
    setLoad(5'd9);
    tick();
    id_rs1 = 5'd3; id_rs2 = 5'd9; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b0;
    #1;
    checks++;
    if (hazard_stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL no_hazard_unused: hazard_stall=%b pcw=%b want 0/1", hazard_stall, pc_write);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || dutStage !== m) begin
      errors++;
      $display("FAIL no_hazard_capture: got %h want %h", dutStage, m);
    end
  endtask

  task automatic test_flush_during_hazard();
    int unsigned stallBefore, flushBefore;
    setLoad(5'd7);
    tick();
    stallBefore = mStall; flushBefore = mFlush;
    id_rs1 = 5'd7; id_uses_rs1 = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL flush_hazard_comb: hazard_stall=%b pcw=%b want 0/1", hazard_stall, pc_write);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || dutStage !== stage_t'(0) ||
        flush_cnt !== CNT_W'(flushBefore + 1) || stall_cnt !== CNT_W'(stallBefore)) begin
      errors++;
      $display("FAIL flush_hazard_regs: stage=%h flush=%0d stall=%0d want 0/%0d/%0d",
               dutStage, flush_cnt, stall_cnt, flushBefore + 1, stallBefore);
    end
  endtask

  task automatic test_hold();
    stage_t held;
    setLoad(5'd4);
    id_ctrl = 8'h86;
    tick();
    held = m;
    for (int i = 0; i < 3; i++) begin
      randData();
      id_rs1 = 5'd4; id_uses_rs1 = 1'b1; hold = 1'b1;
      #1;
      checks++;
      if (pc_write !== 1'b0 || if_id_write !== 1'b0 || hazard_stall !== 1'b0) begin
        errors++;
        $display("FAIL hold_comb[%0d]: pcw=%b ifw=%b hz=%b want 0/0/0",
                 i, pc_write, if_id_write, hazard_stall);
      end
      tick();
      checks++;
      if (dutStage !== held) begin
        errors++;
        $display("FAIL hold_regs[%0d]: got %h want %h", i, dutStage, held);
      end
    end
    flush = 1'b1;
    #1;
    checks++;
    if (pc_write !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold_comb: pcw=%b want 0", pc_write);
    end
    tick();
    flush = 1'b0; hold = 1'b0;
    checks++;
    if (dutStage !== stage_t'(0)) begin
      errors++;
      $display("FAIL flush_hold_bubble: got %h want 0", dutStage);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      setLoad(5'd7);
      tick();
      id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      tick();
    end
    checks++;
    if (stall_cnt !== CNT_W'(CNT_MAX) || mStall != CNT_MAX) begin
      errors++;
      $display("FAIL stall_saturate: stall_cnt=%0d want %0d", stall_cnt, CNT_MAX);
    end
    flush = 1'b1;
    for (int i = 0; i < CNT_MAX + 3; i++) tick();
    flush = 1'b0;
    checks++;
    if (flush_cnt !== CNT_W'(CNT_MAX) || stall_cnt !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("FAIL flush_saturate: flush_cnt=%0d stall_cnt=%0d want %0d/%0d",
               flush_cnt, stall_cnt, CNT_MAX, CNT_MAX);
    end
  endtask

  task automatic test_random();
    // Restart counters so unsaturated counting is exercised too
    reset = 1'b1;
    #1;
    m = '0; mStall = 0; mFlush = 0;
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      randData();
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_ctrl = 8'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      hold = ($urandom_range(0, 6) == 0);
      #1;
      checks++;
      if ({hazard_stall, pc_write, if_id_write} !== {expStall(), expPcWrite(), expPcWrite()}) begin
        errors++;
        $display("FAIL random_comb[%0d]: hz/pcw/ifw=%b%b%b want %b%b%b", i, hazard_stall,
                 pc_write, if_id_write, expStall(), expPcWrite(), expPcWrite());
      end
      tick();
      checks++;
      if (dutStage !== m || stall_cnt !== CNT_W'(mStall) || flush_cnt !== CNT_W'(mFlush)) begin
        errors++;
        $display("FAIL random_regs[%0d]: got %h s=%0d f=%0d want %h s=%0d f=%0d", i, dutStage,
                 stall_cnt, flush_cnt, m, mStall, mFlush);
      end
    end
    flush = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset_initial();
    test_normal();
    test_load_use();
    test_reset_mid_stall();
    test_no_false_hazard();
    test_flush_during_hazard();
    test_hold();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
